// File: rtl/debug_display_ctrl.sv
// Board debug front-end: key debounce, probe channel selection with
// auto-scroll, hold/snapshot, and paging of wide words onto hex digits.
module debug_display_ctrl #(
   parameter  int NCH         = 5,
   parameter  int DW          = 32,
   parameter  int DIGITS      = 4,
   parameter  int DB_CYCLES   = 250000,
   parameter  int AUTO_PERIOD = 50000000,
   localparam int PW          = 4 * DIGITS,
   localparam int NPAGE       = (DW + PW - 1) / PW,
   localparam int SW          = $clog2(NCH),
   localparam int PGW         = (NPAGE > 1) ? $clog2(NPAGE) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [2:0]        nBTN,
   input  logic              AUTO,
   input  logic              HOLD,
   input  logic [NCH*DW-1:0] DATA,
   output logic [SW-1:0]     SEL,
   output logic [NCH-1:0]    SEL_LED,
   output logic [PGW-1:0]    PAGE,
   output logic [PW-1:0]     DIGIT,
   output logic [2:0]        BTN_PULSE
);

   localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int ACW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
   localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_PERIOD - 1);
   localparam logic [SW-1:0]  SEL_LAST  = SW'(NCH - 1);
   localparam logic [PGW-1:0] PAGE_LAST = PGW'(NPAGE - 1);

   logic [2:0]         nbtn_s1, nbtn_s2;
   logic               auto_s1, auto_s2;
   logic               hold_s1, hold_s2;
   logic               hold_d;
   logic [2:0]         db_state, db_state_d;
   logic [DBW-1:0]     db_cnt [3];
   logic [ACW-1:0]     auto_cnt;
   logic               auto_tick;
   logic               man_step;
   logic [SW-1:0]      sel_inc, sel_dec, sel_nxt;
   logic [NCH-1:0]     led_nxt;
   logic [DW-1:0]      live, snapshot, src;
   logic [NPAGE*PW-1:0] src_ext;

   // Two-stage synchronisers; keys idle released so a key held through
   // reset still produces a fresh press
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         nbtn_s1 <= '1;
         nbtn_s2 <= '1;
         auto_s1 <= 1'b0;
         auto_s2 <= 1'b0;
         hold_s1 <= 1'b0;
         hold_s2 <= 1'b0;
      end else begin
         nbtn_s1 <= nBTN;
         nbtn_s2 <= nbtn_s1;
         auto_s1 <= AUTO;
         auto_s2 <= auto_s1;
         hold_s1 <= HOLD;
         hold_s2 <= hold_s1;
      end
   end

   // Per-key debounce: flip the debounced state after DB_CYCLES of disagreement
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         db_state   <= '0;
         db_state_d <= '0;
         for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         db_state_d <= db_state;
         for (int unsigned i = 0; i < 3; i++) begin
            if (~nbtn_s2[i] != db_state[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  db_state[i] <= ~nbtn_s2[i];
                  db_cnt[i]   <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // One-cycle pulse on each released-to-pressed transition
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) BTN_PULSE <= '0;
      else     BTN_PULSE <= db_state & ~db_state_d;
   end

   assign man_step  = BTN_PULSE[0] | BTN_PULSE[1];
   assign auto_tick = (auto_cnt == AUTO_LAST);

   // Auto-scroll tick counter; a manual step restarts the period
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                              auto_cnt <= '0;
      else if (!auto_s2 || hold_s2 || man_step) auto_cnt <= '0;
      else if (auto_tick)                   auto_cnt <= '0;
      else                                  auto_cnt <= auto_cnt + 1'b1;
   end

   // Next channel index and its one-hot LED pattern
   always_comb begin
      sel_inc = (SEL == SEL_LAST) ? '0 : SEL + 1'b1;
      sel_dec = (SEL == '0) ? SEL_LAST : SEL - 1'b1;
      sel_nxt = SEL;
      if (!hold_s2) begin
         if (BTN_PULSE[0] && !BTN_PULSE[1])
            sel_nxt = sel_inc;
         else if (BTN_PULSE[1] && !BTN_PULSE[0])
            sel_nxt = sel_dec;
         else if (!man_step && auto_s2 && auto_tick)
            sel_nxt = sel_inc;
      end
      led_nxt = '0;
      for (int unsigned k = 0; k < NCH; k++) led_nxt[k] = (sel_nxt == SW'(k));
   end

   // Channel index and LED register update together
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         SEL     <= '0;
         SEL_LED <= NCH'(1);
      end else begin
         SEL     <= sel_nxt;
         SEL_LED <= led_nxt;
      end
   end

   // Page stepping is independent of hold
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)               PAGE <= '0;
      else if (BTN_PULSE[2]) PAGE <= (PAGE == PAGE_LAST) ? '0 : PAGE + 1'b1;
   end

   assign live = DATA[SEL*DW +: DW];

   // Capture the selected channel on the rising edge of synced HOLD
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hold_d   <= 1'b0;
         snapshot <= '0;
      end else begin
         hold_d <= hold_s2;
         if (hold_s2 && !hold_d) snapshot <= live;
      end
   end

   // Display source; during the capture cycle live data equals the value being latched
   always_comb begin
      src     = (hold_s2 && hold_d) ? snapshot : live;
      src_ext = '0;
      src_ext[DW-1:0] = src;
   end

   // Registered page slice of the display source
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) DIGIT <= '0;
      else     DIGIT <= src_ext[PAGE*PW +: PW];
   end

endmodule

// File: tb/tb_debug_display_ctrl.sv
// Directed self-checking bench for debug_display_ctrl with short debounce
// and auto-scroll periods.
module tb_debug_display_ctrl;

   localparam int NCH = 5;
   localparam int DW  = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [2:0]        nbtn = 3'b111;
   logic              auto_en = 1'b0;
   logic              hold = 1'b0;
   logic [NCH*DW-1:0] data;
   logic [2:0]        sel;
   logic [4:0]        sel_led;
   logic [0:0]        page;
   logic [15:0]       digit;
   logic [2:0]        btn_pulse;

   int n_assert = 0;
   int n_fail   = 0;
   int pulse_cnt [3] = '{0, 0, 0};
   int p0;

   debug_display_ctrl #(
      .NCH(5), .DW(32), .DIGITS(4), .DB_CYCLES(4), .AUTO_PERIOD(10)
   ) dut (
      .CLK(clk), .RST(rst), .nBTN(nbtn), .AUTO(auto_en), .HOLD(hold),
      .DATA(data), .SEL(sel), .SEL_LED(sel_led), .PAGE(page),
      .DIGIT(digit), .BTN_PULSE(btn_pulse)
   );

   always #5 clk = ~clk;

   // Count every cycle each press pulse is high
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) if (btn_pulse[i]) pulse_cnt[i]++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [2:0] m);
      nbtn = ~m;
      step(12);
      nbtn = 3'b111;
      step(12);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      data = '0;
      data[0*32 +: 32] = 32'h12345678;
      data[1*32 +: 32] = 32'h11111111;
      data[2*32 +: 32] = 32'hDEADBEEF;
      data[3*32 +: 32] = 32'h33333333;
      data[4*32 +: 32] = 32'h44444444;

      // reset state
      step(3);
      chk("rst_sel", sel, 0);
      chk("rst_led", sel_led, 5'b00001);
      chk("rst_page", page, 0);
      chk("rst_digit", digit, 0);
      chk("rst_pulse", btn_pulse, 0);
      rst = 1'b0;
      step(4);
      chk("live_ch0", digit, 16'h5678);

      // 1: short glitch rejected, then a clean press
      nbtn[0] = 1'b0;
      step(3);
      nbtn[0] = 1'b1;
      step(10);
      chk("t1_glitch_cnt", pulse_cnt[0], 0);
      chk("t1_glitch_sel", sel, 0);
      nbtn[0] = 1'b0;
      step(6);
      chk("t1_pulse_e6", btn_pulse, 3'b000);
      step(1);
      chk("t1_pulse_e7", btn_pulse, 3'b001);
      step(1);
      chk("t1_pulse_e8", btn_pulse, 3'b000);
      chk("t1_sel", sel, 1);
      chk("t1_led", sel_led, 5'b00010);
      step(4);
      nbtn = 3'b111;
      step(12);
      chk("t1_release_cnt", pulse_cnt[0], 1);
      chk("t1_sel_after", sel, 1);
      chk("t1_digit", digit, 16'h1111);

      // 2: prev wrap and simultaneous next+prev
      press(3'b010);
      chk("t2_sel0", sel, 0);
      press(3'b010);
      chk("t2_wrap_sel", sel, 4);
      chk("t2_wrap_led", sel_led, 5'b10000);
      chk("t2_digit", digit, 16'h4444);
      press(3'b011);
      chk("t2_both_sel", sel, 4);
      chk("t2_both_cnt0", pulse_cnt[0], 2);
      chk("t2_both_cnt1", pulse_cnt[1], 3);

      // 3: paging
      press(3'b001);
      press(3'b001);
      press(3'b001);
      chk("t3_sel", sel, 2);
      chk("t3_page0", page, 0);
      chk("t3_digit_lo", digit, 16'hBEEF);
      press(3'b100);
      chk("t3_page1", page, 1);
      chk("t3_digit_hi", digit, 16'hDEAD);
      press(3'b100);
      chk("t3_page_wrap", page, 0);
      chk("t3_digit_lo2", digit, 16'hBEEF);

      // 4: auto-scroll and manual step restart
      press(3'b001);
      chk("t4_sel3", sel, 3);
      auto_en = 1'b1;
      step(11);
      chk("t4_before_tick", sel, 3);
      step(1);
      chk("t4_tick1", sel, 4);
      chk("t4_tick1_led", sel_led, 5'b10000);
      step(9);
      chk("t4_before_tick2", sel, 4);
      step(1);
      chk("t4_tick2_wrap", sel, 0);
      nbtn[0] = 1'b0;
      step(7);
      chk("t4_man_before", sel, 0);
      step(1);
      chk("t4_man_step", sel, 1);
      step(4);
      nbtn = 3'b111;
      step(5);
      chk("t4_no_double", sel, 1);
      step(1);
      chk("t4_tick_after_man", sel, 2);
      auto_en = 1'b0;
      step(25);
      chk("t4_auto_off", sel, 2);

      // 5: hold / snapshot
      press(3'b010);
      press(3'b010);
      chk("t5_sel0", sel, 0);
      chk("t5_live", digit, 16'h5678);
      hold = 1'b1;
      step(4);
      chk("t5_hold_digit", digit, 16'h5678);
      data[0*32 +: 32] = 32'h0;
      step(3);
      chk("t5_hold_data", digit, 16'h5678);
      press(3'b001);
      chk("t5_hold_sel", sel, 0);
      chk("t5_hold_led", sel_led, 5'b00001);
      chk("t5_hold_digit2", digit, 16'h5678);
      press(3'b100);
      chk("t5_hold_page", page, 1);
      chk("t5_hold_snap_hi", digit, 16'h1234);
      press(3'b100);
      chk("t5_hold_page0", page, 0);
      hold = 1'b0;
      step(3);
      chk("t5_release", digit, 16'h0000);

      // 6: reset mid-debounce and during auto-scroll; key held across release
      press(3'b001);
      press(3'b100);
      chk("t6_pre_sel", sel, 1);
      chk("t6_pre_digit", digit, 16'h1111);
      auto_en = 1'b1;
      step(5);
      nbtn[0] = 1'b0;
      step(3);
      p0 = pulse_cnt[0];
      rst = 1'b1;
      #1;
      chk("t6_rst_sel", sel, 0);
      chk("t6_rst_led", sel_led, 5'b00001);
      chk("t6_rst_page", page, 0);
      chk("t6_rst_digit", digit, 0);
      chk("t6_rst_pulse", btn_pulse, 0);
      auto_en = 1'b0;
      step(10);
      chk("t6_in_rst_pulse", btn_pulse, 0);
      chk("t6_in_rst_cnt", pulse_cnt[0], p0);
      rst = 1'b0;
      step(6);
      chk("t6_held_e6", btn_pulse, 3'b000);
      step(1);
      chk("t6_held_e7", btn_pulse, 3'b001);
      step(1);
      chk("t6_held_e8", btn_pulse, 3'b000);
      chk("t6_held_sel", sel, 1);
      nbtn = 3'b111;
      step(12);
      chk("t6_held_cnt", pulse_cnt[0], p0 + 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/debug_display_ctrl.md
Name: debug_display_ctrl

Overview:
- Parametrised board debug front-end. It replaces the fixed button-debounce plus 5-way selector pair with a single block.
- Debounces NB raw active-low keys into one-cycle pulses. Steps through NCH 32-bit probe channels, manually or by auto-scroll.
- Pages wide words onto DIGITS seven-segment nibbles and supports a hold/snapshot mode.
- Sits between board I/O and the SEG7DEC instances. BTN_PULSE is also exported so a key can single-step the CPU clock.

Parameters:
- NCH, 5, number of probe channels (2..16).
- DW, 32, width of each channel word.
- DIGITS, 4, hex digits displayed; page width PW = 4*DIGITS bits.
- NPAGE, ceil(DW/PW), number of pages (derived, not overridden).
- DB_CYCLES, 250000, consecutive stable cycles needed to accept a key change (5 ms at 50 MHz).
- AUTO_PERIOD, 50000000, cycles per auto-scroll step.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- nBTN  in  3  raw active-low keys: [0] next channel, [1] previous channel, [2] next page.
- AUTO  in  1  level switch; 1 enables auto-scroll.
- HOLD  in  1  level switch; 1 freezes the display.
- DATA  in  NCH*DW  packed channel words; channel k occupies DATA[k*DW +: DW].
- SEL  out  clog2(NCH)  current channel index.
- SEL_LED  out  NCH  one-hot of SEL.
- PAGE  out  clog2(NPAGE) (min 1)  current page.
- DIGIT  out  PW  displayed nibbles; DIGIT[3:0] drives the rightmost digit.
- BTN_PULSE  out  3  debounced press pulses, one cycle each.

Behaviour:
- Reset (async, RST=1):
  - SEL=0, SEL_LED=1, PAGE=0, DIGIT=0, BTN_PULSE=0.
  - All debounced states = released; debounce and auto counters = 0; snapshot = 0; HOLD edge register = 0.
- Synchronisers: nBTN, AUTO and HOLD each pass through a 2-FF synchroniser before any use.
- Debounce (per key):
  - Counter increments while the synced input differs from the debounced state. It clears when they match.
  - When the counter reaches DB_CYCLES-1 and the input still differs, the debounced state flips and the counter clears.
  - Any glitch shorter than DB_CYCLES causes no change.
- Press pulses:
  - A released→pressed flip raises BTN_PULSE[i] for exactly one cycle, on the following edge.
  - Total latency from a clean nBTN fall: 2 + DB_CYCLES + 1 edges.
  - Release produces no pulse.
  - A key held through reset release is seen as a new press and pulses after the latency above.
- Channel select (only when synced HOLD=0):
  - Next: SEL = SEL+1, wrapping NCH-1→0.
  - Prev: SEL = SEL-1, wrapping 0→NCH-1.
  - Next and prev in the same cycle: no change.
  - SEL_LED is registered and updates on the same edge as SEL.
- Page:
  - Page pulse: PAGE = PAGE+1 mod NPAGE.
  - Page changes are accepted even while HOLD=1.
  - PAGE is retained across channel changes.
- Auto-scroll:
  - While AUTO=1 and HOLD=0, the tick counter counts 0..AUTO_PERIOD-1.
  - At terminal count: SEL advances as for next, and the counter returns to 0.
  - A manual next/prev pulse also clears the counter; the manual step takes precedence and there is no double step.
  - AUTO=0 or HOLD=1: counter held at 0.
- Hold:
  - On the synced HOLD 0→1 edge, snapshot ← DATA[SEL].
  - While HOLD=1: the display source is the snapshot; next, prev and auto are ignored.
  - HOLD 1→0: return to live data the next cycle.
- Display:
  - DIGIT is registered. DIGIT ← source[PAGE*PW +: PW], zero-extended above DW.
  - Latency is 1 cycle from any change of DATA, SEL, PAGE or source.
  - NPAGE=1 is legal; in that case the page key has no effect.

Test Plan:
- Bench parameters: NCH=5, DW=32, DIGITS=4, DB_CYCLES=4, AUTO_PERIOD=10.
1. nBTN[0] low for 3 cycles, then high → no pulse, SEL=0. Then low for 12 cycles → one BTN_PULSE[0] 7 edges after the fall; SEL=1, SEL_LED=5'b00010; nothing further on release.
2. From SEL=0, pulse prev → SEL=4, SEL_LED=5'b10000. Next and prev pressed simultaneously (aligned) → SEL unchanged.
3. DATA ch2=32'hDEADBEEF, SEL=2 → DIGIT=16'hBEEF. Page press → DIGIT=16'hDEAD, PAGE=1. Press again → DIGIT=16'hBEEF, PAGE=0.
4. AUTO=1 from SEL=3 → SEL=4 after 10 cycles, then 0 after 20 cycles. A manual next at cycle 5 → SEL steps once and the next auto step lands 10 cycles after it.
5. ch0=32'h12345678, SEL=0, raise HOLD → DIGIT=16'h5678. Change ch0 to 32'h0 and press next → DIGIT stays 16'h5678, SEL stays 0. Drop HOLD → DIGIT=16'h0000 within 3 cycles.
6. Assert RST mid-debounce and during auto-scroll → all outputs at reset values immediately, with no pulse during reset. A key held across reset release → exactly one pulse 7 edges after release.
